// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer
//   Nibble-serial add/subtract engine. Two requesters share one 4-bit
//   carry-look-ahead adder. An accepted operation is walked through the CLA
//   one nibble per cycle, with the inter-nibble carry held in a register.
//   The result (sum, carry-out, signed overflow) is returned on a
//   valid/ready response handshake.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   reqN_valid/a/b/sub       requester N operation (sub=1: a-b)
//   reqN_ready               combinational accept strobe (IDLE only)
//   rsp_valid/id/sum/cout/ovf registered result, held until rsp_ready
//   rsp_ready                consumer takes the result
//   busy                     engine not idle (registered)

// 4-bit carry-look-ahead adder: all carries from generate/propagate terms.
module carry_look_ahead_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [3:0] p, g;
   logic [4:0] c;

   assign p    = a ^ b;
   assign g    = a & b;
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
   assign sum  = p ^ c[3:0];
   assign cout = c[4];
endmodule

module cla_add_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0_valid,
   input  logic [4*NIBBLES-1:0]   req0_a,
   input  logic [4*NIBBLES-1:0]   req0_b,
   input  logic                   req0_sub,
   output logic                   req0_ready,
   input  logic                   req1_valid,
   input  logic [4*NIBBLES-1:0]   req1_a,
   input  logic [4*NIBBLES-1:0]   req1_b,
   input  logic                   req1_sub,
   output logic                   req1_ready,
   output logic                   rsp_valid,
   output logic                   rsp_id,
   output logic [4*NIBBLES-1:0]   rsp_sum,
   output logic                   rsp_cout,
   output logic                   rsp_ovf,
   input  logic                   rsp_ready,
   output logic                   busy
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]              state;
   logic                    last_grant;
   logic                    id;
   logic                    carry;
   logic [IW-1:0]           idx;
   logic [NIBBLES-1:0][3:0] op_a, op_b, res, res_nxt;

   // Arbitration: a lone requester wins; on a tie the one not served last.
   logic any_valid, grant;
   assign any_valid  = req0_valid | req1_valid;
   assign grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign req0_ready = (state == IDLE) & any_valid & ~grant;
   assign req1_ready = (state == IDLE) & any_valid &  grant;

   logic [W-1:0] sel_a, sel_b;
   logic         sel_sub;
   assign sel_a   = grant ? req1_a   : req0_a;
   assign sel_b   = grant ? req1_b   : req0_b;
   assign sel_sub = grant ? req1_sub : req0_sub;

   // Single shared CLA, fed the current nibble.
   logic [3:0] cla_s;
   logic       cla_co;
   carry_look_ahead_4bit u_cla (
      .a    (op_a[idx]),
      .b    (op_b[idx]),
      .cin  (carry),
      .sum  (cla_s),
      .cout (cla_co)
   );

   always_comb begin
      res_nxt      = res;
      res_nxt[idx] = cla_s;
   end

   // Subtraction is a + ~b + 1: b is inverted at accept and carry seeded
   // with 1, so overflow uses the inverted b's sign bit.
   logic ovf_nxt;
   assign ovf_nxt = (op_a[NIBBLES-1][3] == op_b[NIBBLES-1][3])
                  & (cla_s[3] != op_a[NIBBLES-1][3]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id         <= 1'b0;
         carry      <= 1'b0;
         idx        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         res        <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_sum    <= '0;
         rsp_cout   <= 1'b0;
         rsp_ovf    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  op_a       <= sel_a;
                  op_b       <= sel_sub ? ~sel_b : sel_b;
                  carry      <= sel_sub;
                  id         <= grant;
                  last_grant <= grant;
                  idx        <= '0;
                  state      <= RUN;
                  busy       <= 1'b1;
               end
            end
            RUN: begin
               res   <= res_nxt;
               carry <= cla_co;
               if (idx == LAST) begin
                  idx       <= '0;
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  rsp_id    <= id;
                  rsp_sum   <= res_nxt;
                  rsp_cout  <= cla_co;
                  rsp_ovf   <= ovf_nxt;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_cla_add_sequencer.sv
// Bench for cla_add_sequencer: arithmetic model + scoreboard compared on
// every cycle, plus directed operations with literal expected results.
module tb_cla_add_sequencer;
   localparam int N = 4;
   localparam int W = 4 * N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 0, req0_sub = 0, req1_valid = 0, req1_sub = 0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_ready, req1_ready;
   logic         rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy;
   logic [W-1:0] rsp_sum;
   logic         rsp_ready = 1'b1;

   cla_add_sequencer #(.NIBBLES(N)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
      .req0_sub(req0_sub), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
      .req1_sub(req1_sub), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      logic         id;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t exp_q[$];
   int   acc_ord[$];

   // Plain arithmetic model: unsigned wrap, cout = carry (add) / no-borrow (sub),
   // signed overflow from operand and result signs.
   function automatic exp_t model(input logic id, input logic [W-1:0] a, b,
                                  input logic sub, input int acc);
      exp_t e;
      logic [W:0] full;
      e.id  = id;
      e.acc = acc;
      if (sub) begin
         e.sum  = a - b;
         e.cout = (a >= b);
         e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
      end else begin
         full   = {1'b0, a} + {1'b0, b};
         e.sum  = full[W-1:0];
         e.cout = full[W];
         e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
      end
      return e;
   endfunction

   // Compare process: runs every cycle on the falling edge.
   logic         prev_v = 0, prev_r = 0, prev_id = 0, prev_c = 0, prev_o = 0;
   logic [W-1:0] prev_sum = '0;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         prev_v <= 1'b0;
      end else begin
         chk("ready_exclusive", {31'b0, req0_ready & req1_ready}, 0);
         if (req0_ready | req1_ready) chk("ready_only_idle", {31'b0, busy}, 0);
         if (req0_valid && req0_ready) begin
            exp_q.push_back(model(1'b0, req0_a, req0_b, req0_sub, cyc));
            acc_ord.push_back(0);
         end
         if (req1_valid && req1_ready) begin
            exp_q.push_back(model(1'b1, req1_a, req1_b, req1_sub, cyc));
            acc_ord.push_back(1);
         end
         if (rsp_valid && !prev_v) begin
            if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
            else chk("rsp_latency", cyc - exp_q[0].acc, N + 1);
         end
         if (rsp_valid && prev_v && !prev_r) begin
            chk("hold_sum", rsp_sum, prev_sum);
            chk("hold_id", {31'b0, rsp_id}, {31'b0, prev_id});
            chk("hold_cout", {31'b0, rsp_cout}, {31'b0, prev_c});
            chk("hold_ovf", {31'b0, rsp_ovf}, {31'b0, prev_o});
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("rsp_without_op", 1, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("model_id", {31'b0, rsp_id}, {31'b0, e.id});
               chk("model_sum", rsp_sum, e.sum);
               chk("model_cout", {31'b0, rsp_cout}, {31'b0, e.cout});
               chk("model_ovf", {31'b0, rsp_ovf}, {31'b0, e.ovf});
            end
         end
         prev_v   <= rsp_valid;
         prev_r   <= rsp_ready;
         prev_id  <= rsp_id;
         prev_sum <= rsp_sum;
         prev_c   <= rsp_cout;
         prev_o   <= rsp_ovf;
      end
   end

   task automatic drive(input bit id, input logic [W-1:0] a, b, input bit sub);
      if (id) begin req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1; end
      else    begin req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1; end
   endtask

   // Wait (bounded) for the given requester to be accepted; returns accept cycle.
   task automatic wait_accept(input bit id, input string tag, output int acc);
      bit got = 0;
      acc = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) begin got = 1; acc = cyc; end
      end
      if (!got) chk({tag, "_accept_timeout"}, 0, 1);
   endtask

   task automatic do_op(input bit id, input logic [W-1:0] a, b, input bit sub,
                        input logic [W-1:0] es, input bit ec, eo, input string tag);
      int  acc;
      bit  got = 0;
      @(posedge clk); #1;
      drive(id, a, b, sub);
      wait_accept(id, tag, acc);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) got = 1;
      end
      if (!got) chk({tag, "_rsp_timeout"}, 0, 1);
      else begin
         chk({tag, "_sum"}, rsp_sum, es);
         chk({tag, "_cout"}, {31'b0, rsp_cout}, {31'b0, ec});
         chk({tag, "_ovf"}, {31'b0, rsp_ovf}, {31'b0, eo});
         chk({tag, "_id"}, {31'b0, rsp_id}, {31'b0, id});
         chk({tag, "_latency"}, cyc - acc, 5);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1; rst = 0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      bit got;
      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rsp_id", {31'b0, rsp_id}, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_cout", {31'b0, rsp_cout}, 0);
      chk("rst_rsp_ovf", {31'b0, rsp_ovf}, 0);
      chk("rst_busy", {31'b0, busy}, 0);

      // Directed arithmetic
      do_op(0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, "add_wrap");
      do_op(1, 16'h0005, 16'h0007, 1, 16'hFFFE, 0, 0, "sub_borrow");
      do_op(1, 16'h0007, 16'h0005, 1, 16'h0002, 1, 0, "sub_noborrow");
      do_op(0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, "add_ovf");
      do_op(1, 16'h8000, 16'h0001, 1, 16'h7FFF, 1, 1, "sub_ovf");
      do_op(0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0, "add_plain");

      // Arbitration: both valid continuously after reset
      do_reset();
      acc_ord.delete();
      drive(0, 16'h1111, 16'h0101, 0);
      drive(1, 16'h9000, 16'h0234, 1);
      got = 0;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         if (acc_ord.size() >= 4) got = 1;
      end
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      if (!got) chk("arb_timeout", 0, 1);
      else for (int i = 0; i < 4; i++) chk($sformatf("arb_order%0d", i), acc_ord[i], i % 2);
      idle_cycles(10);

      // Back-pressure with a competing requester waiting
      rsp_ready = 0;
      drive(0, 16'h1234, 16'h4321, 0);
      wait_accept(0, "bp", acc);
      @(posedge clk); #1;
      req0_valid = 0;
      drive(1, 16'h0001, 16'h0001, 0);
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (rsp_valid) got = 1;
      end
      if (!got) chk("bp_rsp_timeout", 0, 1);
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         chk("bp_valid", {31'b0, rsp_valid}, 1);
         chk("bp_sum", rsp_sum, 16'h5555);
         chk("bp_ready0", {31'b0, req0_ready}, 0);
         chk("bp_ready1", {31'b0, req1_ready}, 0);
         chk("bp_busy", {31'b0, busy}, 1);
      end
      @(posedge clk); #1;
      rsp_ready = 1;
      req1_valid = 0;
      @(negedge clk);
      chk("bp_handshake", {31'b0, rsp_valid & rsp_ready}, 1);
      @(negedge clk);
      chk("bp_idle_busy", {31'b0, busy}, 0);
      chk("bp_idle_valid", {31'b0, rsp_valid}, 0);
      idle_cycles(2);

      // Tie after back-pressure: req0 was last served, so req1 wins now
      acc_ord.delete();
      drive(0, 16'h0010, 16'h0020, 0);
      drive(1, 16'h0030, 16'h0040, 0);
      wait_accept(1, "tie_rr", acc);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      idle_cycles(10);
      if (acc_ord.size() > 0) chk("tie_rr_first", acc_ord[0], 1);

      // Reset mid-RUN at idx=2
      drive(0, 16'h1111, 16'h2222, 0);
      wait_accept(0, "abort", acc);
      @(posedge clk); #1;
      req0_valid = 0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_valid", {31'b0, rsp_valid}, 0);
      chk("abort_sum", rsp_sum, 0);
      chk("abort_id", {31'b0, rsp_id}, 0);
      chk("abort_cout", {31'b0, rsp_cout}, 0);
      chk("abort_ovf", {31'b0, rsp_ovf}, 0);
      for (int t = 0; t < N + 4; t++) begin
         @(negedge clk);
         chk("abort_no_rsp", {31'b0, rsp_valid}, 0);
      end
      acc_ord.delete();
      @(posedge clk); #1;
      drive(0, 16'h0002, 16'h0003, 0);
      drive(1, 16'h0004, 16'h0005, 1);
      wait_accept(0, "tie_after_rst", acc);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      idle_cycles(10);
      if (acc_ord.size() > 0) chk("tie_after_rst_first", acc_ord[0], 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end
endmodule
